// File: rtl/sd_frame_writer.sv
// -----------------------------------------------------------------------------
// sd_frame_writer
//
// Writer-side feeder for the SDRAM frame buffer. It takes the raw byte stream
// of a 24-bit BMP file from the SD-card reader and drops the file header. Each
// B,G,R byte triplet after the header is packed into one RGB565 word, and that
// word is pushed into the SDRAM write FIFO. At the start of every frame it
// pulses wr_load, which sends the SDRAM write address back to 0.
//
// Parameters
//   HEADER_BYTES : leading bytes discarded after frame start (BMP header)
//   H_PIX, V_PIX : frame geometry. H_PIX*3 must be a multiple of 4, because
//                  BMP row padding is not handled.
//
// Ports
//   clk_sd          in   block clock, rising edge
//   sd_rst          in   asynchronous active-high reset
//   sdram_init_done in   frames are accepted only while high (sampled in IDLE)
//   frame_start     in   single-cycle pulse that starts or restarts a frame
//   byte_valid      in   byte_data valid this cycle (no backpressure)
//   byte_data[7:0]  in   image byte
//   wr_load         out  SDRAM write-address reset pulse (the LOAD cycle)
//   sys_we          out  FIFO write enable, one cycle per pixel
//   sys_data_in[15:0] out RGB565 {R[7:3],G[7:2],B[7:3]}
//   busy            out  high from LOAD until the last pixel is written
//   frame_done      out  one-cycle pulse together with the final sys_we
//   pix_cnt[19:0]   out  pixels written in the current frame
// -----------------------------------------------------------------------------
module sd_frame_writer #(
    parameter int HEADER_BYTES = 54,
    parameter int H_PIX        = 1024,
    parameter int V_PIX        = 768
) (
    input  logic        clk_sd,
    input  logic        sd_rst,
    input  logic        sdram_init_done,
    input  logic        frame_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        wr_load,
    output logic        sys_we,
    output logic [15:0] sys_data_in,
    output logic        busy,
    output logic        frame_done,
    output logic [19:0] pix_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_HEADER = 2'd2;
    localparam logic [1:0] ST_PIXEL  = 2'd3;

    localparam int              HDR_W     = (HEADER_BYTES > 1) ? $clog2(HEADER_BYTES + 1) : 1;
    localparam logic [HDR_W-1:0] HDR_LAST = HDR_W'(HEADER_BYTES - 1);
    localparam logic [19:0]     LAST_PIX  = 20'(H_PIX * V_PIX - 1);

    logic [1:0]       state_q, state_d;
    logic             wr_load_q, wr_load_d;
    logic             sys_we_q, sys_we_d;
    logic [15:0]      data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [19:0]      pix_q, pix_d;
    logic [HDR_W-1:0] hdr_q, hdr_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       b_q, b_d;
    logic [7:0]       g_q, g_d;
    logic             go_load_s;

    // Only the top bits of B and G reach RGB565; the low bits are kept so that
    // the byte registers hold whole bytes.
    logic unused_bits_s;
    assign unused_bits_s = ^{b_q[2:0], g_q[1:0]};

    // Truncate one B,G,R triplet to RGB565.
    function automatic logic [15:0] pack_rgb565(input logic [7:0] r,
                                                input logic [4:0] g_hi_unused_free_b,
                                                input logic [5:0] g6);
        // r supplies the red field; g6 and the 5-bit blue field fill the rest.
        return {r[7:3], g6, g_hi_unused_free_b};
    endfunction

    // IDLE accepts a start only when the SDRAM is ready. In any other state a
    // start aborts the frame, whatever sdram_init_done is doing.
    assign go_load_s = frame_start && ((state_q != ST_IDLE) || sdram_init_done);

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        wr_load_d = 1'b0;
        sys_we_d  = 1'b0;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pix_d     = pix_q;
        hdr_d     = hdr_q;
        idx_d     = idx_q;
        b_d       = b_q;
        g_d       = g_q;

        if (go_load_s) begin
            // Start or restart: any partial triplet and the byte arriving in
            // this cycle are dropped.
            state_d   = ST_LOAD;
            wr_load_d = 1'b1;
            busy_d    = 1'b1;
            pix_d     = 20'd0;
            hdr_d     = {HDR_W{1'b0}};
            idx_d     = 2'd0;
            b_d       = 8'd0;
            g_d       = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_LOAD: begin
                    // A byte in the LOAD cycle is dropped on purpose.
                    hdr_d = {HDR_W{1'b0}};
                    idx_d = 2'd0;
                    if (HEADER_BYTES == 0) begin
                        state_d = ST_PIXEL;
                    end else begin
                        state_d = ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (byte_valid) begin
                        hdr_d = hdr_q + {{(HDR_W-1){1'b0}}, 1'b1};
                        if (hdr_q == HDR_LAST) begin
                            state_d = ST_PIXEL;
                        end else begin
                            state_d = ST_HEADER;
                        end
                    end else begin
                        state_d = ST_HEADER;
                    end
                end
                ST_PIXEL: begin
                    if (byte_valid) begin
                        case (idx_q)
                            2'd0: begin
                                b_d   = byte_data;
                                idx_d = 2'd1;
                            end
                            2'd1: begin
                                g_d   = byte_data;
                                idx_d = 2'd2;
                            end
                            2'd2: begin
                                sys_we_d = 1'b1;
                                data_d   = pack_rgb565(byte_data, b_q[7:3], g_q[7:2]);
                                pix_d    = pix_q + 20'd1;
                                idx_d    = 2'd0;
                                if (pix_q == LAST_PIX) begin
                                    done_d  = 1'b1;
                                    busy_d  = 1'b0;
                                    state_d = ST_IDLE;
                                end else begin
                                    state_d = ST_PIXEL;
                                end
                            end
                            default: begin
                                idx_d = 2'd0;
                            end
                        endcase
                    end else begin
                        state_d = ST_PIXEL;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; the reset clears everything at once, even mid-frame.
    always_ff @(posedge clk_sd or posedge sd_rst) begin
        if (sd_rst) begin
            state_q   <= ST_IDLE;
            wr_load_q <= 1'b0;
            sys_we_q  <= 1'b0;
            data_q    <= 16'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pix_q     <= 20'd0;
            hdr_q     <= {HDR_W{1'b0}};
            idx_q     <= 2'd0;
            b_q       <= 8'd0;
            g_q       <= 8'd0;
        end else begin
            state_q   <= state_d;
            wr_load_q <= wr_load_d;
            sys_we_q  <= sys_we_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pix_q     <= pix_d;
            hdr_q     <= hdr_d;
            idx_q     <= idx_d;
            b_q       <= b_d;
            g_q       <= g_d;
        end
    end

    assign wr_load     = wr_load_q;
    assign sys_we      = sys_we_q;
    assign sys_data_in = data_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign pix_cnt     = pix_q;

endmodule
